// File: rtl/tetris_status_tx.sv
// SPI mode-0 slave transmitter returning a 6-byte game-status frame to the MCU.
// sck/ce are oversampled in game_clk; game state is snapshotted when each transaction opens.
`timescale 1ns/1ps
module tetris_status_tx #(
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        game_clk,
   input  logic        reset_n,
   input  logic        sck,
   input  logic        ce,
   input  logic [15:0] score,
   input  logic [7:0]  lines,
   input  logic [3:0]  status_flags,
   output logic        sdo,
   output logic        sdo_en,
   output logic        busy,
   output logic        frame_done,
   output logic [3:0]  seq
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] sck_sync_q, ce_sync_q;
   logic                   sck_hist_q, ce_hist_q;
   logic [47:0]            shift_q;
   logic [5:0]             bit_cnt_q;
   logic [3:0]             seq_q;
   logic                   frame_done_q;

   logic       sck_s, ce_s;
   logic       sck_rise, sck_fall, ce_rise, ce_fall;
   logic [7:0] byte1, checksum;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ce_s     = ce_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_hist_q;
   assign sck_fall = ~sck_s & sck_hist_q;
   assign ce_rise  = ce_s & ~ce_hist_q;
   assign ce_fall  = ~ce_s & ce_hist_q;

   assign byte1    = {seq_q, status_flags};
   assign checksum = byte1 ^ score[15:8] ^ score[7:0] ^ lines;

   always_ff @(posedge game_clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         sck_sync_q   <= '0;
         ce_sync_q    <= '0;
         sck_hist_q   <= 1'b0;
         ce_hist_q    <= 1'b0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         seq_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         ce_sync_q    <= {ce_sync_q[SYNC_STAGES-2:0], ce};
         sck_hist_q   <= sck_s;
         ce_hist_q    <= ce_s;
         frame_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ce_rise) state_q <= StLoad;
            end
            StLoad: begin
               if (ce_fall) begin
                  state_q <= StIdle;
               end else begin
                  shift_q   <= {SYNC_BYTE, byte1, score, lines, checksum};
                  bit_cnt_q <= '0;
                  state_q   <= StShift;
               end
            end
            StShift: begin
               // ce_fall wins over any coincident sck edge
               if (ce_fall) begin
                  state_q <= StIdle;
               end else begin
                  if (sck_fall) shift_q <= {shift_q[46:0], 1'b0};
                  if (sck_rise) begin
                     if (bit_cnt_q == 6'd47) begin
                        bit_cnt_q    <= 6'd48;
                        frame_done_q <= 1'b1;
                        seq_q        <= seq_q + 4'd1;
                        state_q      <= StDone;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                     end
                  end
               end
            end
            StDone: begin
               if (ce_fall) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sdo        = (state_q == StShift) & ce_s & shift_q[47];
   assign sdo_en     = ce_s;
   assign busy       = (state_q == StLoad) | (state_q == StShift);
   assign frame_done = frame_done_q;
   assign seq        = seq_q;

endmodule

// File: tb/tb_tetris_status_tx.sv
// Self-checking bench for tetris_status_tx: acts as the SPI master and compares each
// sampled frame against a byte-level model of the status frame.
`timescale 1ns/1ps
module tb_tetris_status_tx;

   logic        game_clk = 1'b0;
   logic        reset_n  = 1'b0;
   logic        sck      = 1'b0;
   logic        ce       = 1'b0;
   logic [15:0] score    = '0;
   logic [7:0]  lines    = '0;
   logic [3:0]  status_flags = '0;
   logic        sdo, sdo_en, busy, frame_done;
   logic [3:0]  seq;

   int n_checks = 0;
   int n_pass   = 0;
   int fd_cnt   = 0;
   int seq_m    = 0;

   tetris_status_tx #(
      .SYNC_BYTE   (8'hA5),
      .SYNC_STAGES (2)
   ) dut (
      .game_clk     (game_clk),
      .reset_n      (reset_n),
      .sck          (sck),
      .ce           (ce),
      .score        (score),
      .lines        (lines),
      .status_flags (status_flags),
      .sdo          (sdo),
      .sdo_en       (sdo_en),
      .busy         (busy),
      .frame_done   (frame_done),
      .seq          (seq)
   );

   always #5 game_clk = ~game_clk;

   // Counts cycles with frame_done high, so a stretched pulse shows up as >1
   always @(negedge game_clk) if (frame_done) fd_cnt++;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge game_clk);
   endtask

   function automatic logic [47:0] model_frame(input int s, input logic [3:0] f,
                                               input logic [15:0] sc, input logic [7:0] ln);
      logic [7:0] b [6];
      b[0] = 8'hA5;
      b[1] = 8'((s % 16) * 16 + int'(f));
      b[2] = 8'(sc / 256);
      b[3] = 8'(sc % 256);
      b[4] = ln;
      b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
      return {b[0], b[1], b[2], b[3], b[4], b[5]};
   endfunction

   task automatic do_reset();
      ce = 1'b0;
      sck = 1'b0;
      reset_n = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      seq_m = 0;
      cycles(2);
   endtask

   // MCU side: sample sdo just before each rising sck; optionally swap score mid-frame
   // or drop ce together with the last rising edge.
   task automatic run_frame(input int npulses, input int chg_at, input logic [15:0] chg_score,
                            input bit coinc_drop, output logic [47:0] got);
      got = '0;
      fd_cnt = 0;
      ce = 1'b1;
      cycles(10);
      for (int i = 0; i < npulses; i++) begin
         got = {got[46:0], sdo};
         sck = 1'b1;
         if (coinc_drop && i == npulses - 1) ce = 1'b0;
         cycles(6);
         sck = 1'b0;
         cycles(6);
         if (i + 1 == chg_at) score = chg_score;
      end
      if (npulses == 48 && !coinc_drop) begin
         check_eq("done_sdo", 64'(sdo), 64'd0);
         check_eq("done_busy", 64'(busy), 64'd0);
         check_eq("done_sdo_en", 64'(sdo_en), 64'd1);
         seq_m = (seq_m + 1) % 16;
      end
      ce = 1'b0;
      cycles(8);
      check_eq("idle_sdo_en", 64'(sdo_en), 64'd0);
   endtask

   logic [47:0] got;

   initial begin
      // Reset state
      reset_n = 1'b0;
      cycles(3);
      check_eq("rst_sdo", 64'(sdo), 64'd0);
      check_eq("rst_sdo_en", 64'(sdo_en), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_frame_done", 64'(frame_done), 64'd0);
      check_eq("rst_seq", 64'(seq), 64'd0);
      reset_n = 1'b1;
      cycles(2);

      // Basic and second frame
      score = 16'h1234; lines = 8'h07; status_flags = 4'h5;
      run_frame(48, -1, 16'h0, 1'b0, got);
      check_eq("basic_frame", 64'(got), 64'h A5_05_12_34_07_24);
      check_eq("basic_fd", 64'(fd_cnt), 64'd1);
      check_eq("basic_seq", 64'(seq), 64'd1);
      run_frame(48, -1, 16'h0, 1'b0, got);
      check_eq("second_frame", 64'(got), 64'h A5_15_12_34_07_34);
      check_eq("second_seq", 64'(seq), 64'd2);

      // Abort after 10 pulses from a fresh reset
      do_reset();
      run_frame(10, -1, 16'h0, 1'b0, got);
      check_eq("abort_fd", 64'(fd_cnt), 64'd0);
      check_eq("abort_seq", 64'(seq), 64'd0);
      run_frame(48, -1, 16'h0, 1'b0, got);
      check_eq("after_abort_frame", 64'(got), 64'h A5_05_12_34_07_24);

      // Snapshot: score changes mid-frame
      run_frame(48, 3, 16'hBEEF, 1'b0, got);
      check_eq("snap_frame", 64'(got), 64'(model_frame(1, 4'h5, 16'h1234, 8'h07)));
      run_frame(48, -1, 16'h0, 1'b0, got);
      check_eq("snap_next", 64'(got), 64'(model_frame(2, 4'h5, 16'hBEEF, 8'h07)));
      check_eq("snap_seq", 64'(seq), 64'(seq_m));

      // Reset mid-frame at bit 20
      ce = 1'b1;
      cycles(10);
      for (int i = 0; i < 20; i++) begin
         sck = 1'b1; cycles(6);
         sck = 1'b0; cycles(6);
      end
      check_eq("mid_busy_pre", 64'(busy), 64'd1);
      reset_n = 1'b0;
      ce = 1'b0;
      cycles(1);
      check_eq("midrst_sdo", 64'(sdo), 64'd0);
      check_eq("midrst_busy", 64'(busy), 64'd0);
      check_eq("midrst_seq", 64'(seq), 64'd0);
      reset_n = 1'b1;
      seq_m = 0;
      cycles(4);

      // Seq wrap
      score = 16'h1234;
      for (int k = 0; k < 16; k++) run_frame(48, -1, 16'h0, 1'b0, got);
      check_eq("wrap_seq", 64'(seq), 64'd0);
      run_frame(48, -1, 16'h0, 1'b0, got);
      check_eq("wrap_byte1", 64'(got[39:32]), 64'h05);

      // ce_fall coincident with the 48th sck rise
      run_frame(48, -1, 16'h0, 1'b1, got);
      check_eq("coinc_fd", 64'(fd_cnt), 64'd0);
      check_eq("coinc_seq", 64'(seq), 64'(seq_m));

      // Randomized frames, some aborted
      for (int k = 0; k < 10; k++) begin
         int np;
         int s0;
         logic [47:0] exp;
         score        = 16'($urandom);
         lines        = 8'($urandom);
         status_flags = 4'($urandom);
         np  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 47)) : 48;
         s0  = seq_m;
         exp = model_frame(s0, status_flags, score, lines);
         run_frame(np, -1, 16'h0, 1'b0, got);
         if (np == 48) check_eq("rand_frame", 64'(got), 64'(exp));
         check_eq("rand_fd", 64'(fd_cnt), (np == 48) ? 64'd1 : 64'd0);
         check_eq("rand_seq", 64'(seq), 64'(seq_m));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
